// File: rtl/core_pkg.sv
// core_pkg: shared decode types, opcode constants and ALU-code helper for the RV32I core
package core_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_OR   = 4'b1010,
        ALU_AND  = 4'b1011
    } alu_op_e;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_ZERO = 2'b10
    } a_sel_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Control portion of the ID/EX slot; immediate and PC are held separately
    // because their width follows X_LEN.
    typedef struct packed {
        alu_op_e    alu_op;
        a_sel_e     a_sel;
        logic       b_sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       branch;
        logic       jump;
        logic [2:0] funct3;
        logic       illegal;
    } ctrl_t;

    // alt selects SUB over ADD and SRA over SRL; ignored for other funct3 values.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_decoder_imm_gen.sv
// imm_gen: combinational RV32I immediate extractor, sign-extended to X_LEN
//   instr_i    in  32     instruction word
//   imm_type_i in  3      immediate format (I, S, B, U, J)
//   imm_o      out X_LEN  sign-extended immediate
module imm_gen
    import core_pkg::*;
#(
    parameter int X_LEN = 32
) (
    input  logic [31:0]      instr_i,
    input  imm_type_e        imm_type_i,
    output logic [X_LEN-1:0] imm_o
);

    logic [31:0] imm32;
    logic        unused_opcode;

    assign unused_opcode = ^instr_i[6:0];

    always_comb begin
        imm32 = (imm_type_i == IMM_S) ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
                (imm_type_i == IMM_B) ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
                (imm_type_i == IMM_U) ? {instr_i[31:12], 12'b0} :
                (imm_type_i == IMM_J) ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
                                        {{20{instr_i[31]}}, instr_i[31:20]};
    end

    assign imm_o = X_LEN'($signed(imm32));

endmodule

// File: rtl/id_ex_decoder.sv
// id_ex_decoder: RV32I decode stage feeding a single registered ID/EX slot
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_valid_i/in_ready_o         IF handshake; instr_i, pc_i accepted together
//   flush_i                       squash held and incoming instruction
//   out_valid_o/out_ready_i       EX handshake on the slot
//   alu_op_o, a_sel_o, b_sel_o    ALU operation and operand selects
//   imm_o, rs1_o, rs2_o, rd_o     immediate and register indices
//   reg_we_o .. jump_o, funct3_o  control flags and funct3 for LSU/branch unit
//   pc_o, illegal_o               registered PC, unsupported-encoding flag
module id_ex_decoder
    import core_pkg::*;
#(
    parameter int X_LEN = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [X_LEN-1:0] pc_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [3:0]       alu_op_o,
    output logic [1:0]       a_sel_o,
    output logic             b_sel_o,
    output logic [X_LEN-1:0] imm_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic             reg_we_o,
    output logic             mem_re_o,
    output logic             mem_we_o,
    output logic             branch_o,
    output logic             jump_o,
    output logic [2:0]       funct3_o,
    output logic [X_LEN-1:0] pc_o,
    output logic             illegal_o
);

    logic [2:0]       f3;
    logic [6:0]       f7;
    ctrl_t            dec;
    imm_type_e        imm_type;
    logic             legal;
    logic [X_LEN-1:0] dec_imm;
    logic             accept;
    logic             valid_d, valid_q;
    ctrl_t            ctrl_d, ctrl_q;
    logic [X_LEN-1:0] imm_d, imm_q;
    logic [X_LEN-1:0] pc_d, pc_q;

    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        dec.a_sel  = A_RS1;
        dec.rs1    = instr_i[19:15];
        dec.rs2    = instr_i[24:20];
        dec.rd     = instr_i[11:7];
        dec.funct3 = f3;
        imm_type   = IMM_I;
        legal      = 1'b1;
        case (instr_i[6:0])
            OPC_OP: begin
                dec.alu_op = alu_from_f3(f3, f7[5]);
                dec.reg_we = 1'b1;
                legal      = (f7 == F7_ZERO) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
            end
            OPC_OP_IMM: begin
                // Only shift-right immediates carry an alternate form; ADDI has no SUBI.
                dec.alu_op = alu_from_f3(f3, f3 == 3'b101 && f7[5]);
                dec.b_sel  = 1'b1;
                dec.reg_we = 1'b1;
                legal      = (f3 == 3'b001) ? (f7 == F7_ZERO) :
                             (f3 == 3'b101) ? (f7 == F7_ZERO || f7 == F7_ALT) : 1'b1;
            end
            OPC_LOAD: begin
                dec.b_sel  = 1'b1;
                dec.mem_re = 1'b1;
                dec.reg_we = 1'b1;
            end
            OPC_STORE: begin
                dec.b_sel  = 1'b1;
                dec.mem_we = 1'b1;
                imm_type   = IMM_S;
            end
            OPC_BRANCH: begin
                dec.a_sel  = A_PC;
                dec.b_sel  = 1'b1;
                dec.branch = 1'b1;
                imm_type   = IMM_B;
            end
            OPC_JAL: begin
                dec.a_sel  = A_PC;
                dec.b_sel  = 1'b1;
                dec.jump   = 1'b1;
                dec.reg_we = 1'b1;
                imm_type   = IMM_J;
            end
            OPC_JALR: begin
                dec.b_sel  = 1'b1;
                dec.jump   = 1'b1;
                dec.reg_we = 1'b1;
                legal      = (f3 == 3'b000);
            end
            OPC_LUI: begin
                dec.a_sel  = A_ZERO;
                dec.b_sel  = 1'b1;
                dec.reg_we = 1'b1;
                imm_type   = IMM_U;
            end
            OPC_AUIPC: begin
                dec.a_sel  = A_PC;
                dec.b_sel  = 1'b1;
                dec.reg_we = 1'b1;
                imm_type   = IMM_U;
            end
            default: legal = 1'b0;
        endcase
        // Illegal instructions still flow to EX for trapping but must have no side effects.
        if (!legal) begin
            dec.alu_op = ALU_ADD;
            dec.reg_we = 1'b0;
            dec.mem_re = 1'b0;
            dec.mem_we = 1'b0;
            dec.branch = 1'b0;
            dec.jump   = 1'b0;
        end
        dec.illegal = !legal;
        if (dec.rd == 5'd0) dec.reg_we = 1'b0;
    end

    imm_gen #(.X_LEN(X_LEN)) u_imm_gen (
        .instr_i    (instr_i),
        .imm_type_i (imm_type),
        .imm_o      (dec_imm)
    );

    assign in_ready_o = !out_valid_o || out_ready_i;

    // Flush wins over both accept and hold; payload is left stale on flush.
    always_comb begin
        accept  = in_valid_i && in_ready_o && !flush_i;
        valid_d = flush_i ? 1'b0 : accept ? 1'b1 : out_ready_i ? 1'b0 : valid_q;
        ctrl_d  = accept ? dec : ctrl_q;
        imm_d   = accept ? dec_imm : imm_q;
        pc_d    = accept ? pc_i : pc_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid_o = valid_q;
    assign alu_op_o    = ctrl_q.alu_op;
    assign a_sel_o     = ctrl_q.a_sel;
    assign b_sel_o     = ctrl_q.b_sel;
    assign imm_o       = imm_q;
    assign rs1_o       = ctrl_q.rs1;
    assign rs2_o       = ctrl_q.rs2;
    assign rd_o        = ctrl_q.rd;
    assign reg_we_o    = ctrl_q.reg_we;
    assign mem_re_o    = ctrl_q.mem_re;
    assign mem_we_o    = ctrl_q.mem_we;
    assign branch_o    = ctrl_q.branch;
    assign jump_o      = ctrl_q.jump;
    assign funct3_o    = ctrl_q.funct3;
    assign pc_o        = pc_q;
    assign illegal_o   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_decoder.sv
// tb_id_ex_decoder: directed table-driven bench for the ID/EX decoder slot
module tb_id_ex_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr, pc;
    logic [3:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm, pc_out;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_we, mem_re, mem_we, branch, jump, illegal;
    logic [2:0]  funct3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_decoder #(.X_LEN(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .instr_i     (instr),
        .pc_i        (pc),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .alu_op_o    (alu_op),
        .a_sel_o     (a_sel),
        .b_sel_o     (b_sel),
        .imm_o       (imm),
        .rs1_o       (rs1),
        .rs2_o       (rs2),
        .rd_o        (rd),
        .reg_we_o    (reg_we),
        .mem_re_o    (mem_re),
        .mem_we_o    (mem_we),
        .branch_o    (branch),
        .jump_o      (jump),
        .funct3_o    (funct3),
        .pc_o        (pc_out),
        .illegal_o   (illegal)
    );

    // flags = {reg_we, mem_re, mem_we, branch, jump}; zero masks mean "don't care".
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  alu;
        logic [1:0]  a;
        logic        am;
        logic        b;
        logic        bm;
        logic [31:0] imm;
        logic [31:0] imask;
        logic [4:0]  rs1;
        logic        rs1m;
        logic [4:0]  rs2;
        logic        rs2m;
        logic [4:0]  rd;
        logic        rdm;
        logic [4:0]  flags;
        logic        ill;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"add",      32'h002081B3, 4'h0, 2'd0, 1, 0, 1, 32'h0,        32'h0,        5'd1, 1, 5'd2, 1, 5'd3,  1, 5'b10000, 0};
        vecs[1]  = '{"sub",      32'h407302B3, 4'h1, 2'd0, 1, 0, 1, 32'h0,        32'h0,        5'd6, 1, 5'd7, 1, 5'd5,  1, 5'b10000, 0};
        vecs[2]  = '{"srai",     32'h40315093, 4'h7, 2'd0, 1, 1, 1, 32'h3,        32'h1F,       5'd2, 1, 5'd0, 0, 5'd1,  1, 5'b10000, 0};
        vecs[3]  = '{"addi_m1",  32'hFFF00093, 4'h0, 2'd0, 1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1, 5'd0, 0, 5'd1,  1, 5'b10000, 0};
        vecs[4]  = '{"lw",       32'h00812283, 4'h0, 2'd0, 1, 1, 1, 32'h8,        32'hFFFFFFFF, 5'd2, 1, 5'd0, 0, 5'd5,  1, 5'b11000, 0};
        vecs[5]  = '{"sw",       32'hFE612E23, 4'h0, 2'd0, 1, 1, 1, 32'hFFFFFFFC, 32'hFFFFFFFF, 5'd2, 1, 5'd6, 1, 5'd0,  0, 5'b00100, 0};
        vecs[6]  = '{"beq",      32'h00208863, 4'h0, 2'd1, 1, 1, 1, 32'h10,       32'hFFFFFFFF, 5'd1, 1, 5'd2, 1, 5'd0,  0, 5'b00010, 0};
        vecs[7]  = '{"jal_m4",   32'hFFDFF0EF, 4'h0, 2'd1, 1, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFFF, 5'd0, 0, 5'd0, 0, 5'd1,  1, 5'b10001, 0};
        vecs[8]  = '{"jalr_x0",  32'h00008067, 4'h0, 2'd0, 1, 1, 1, 32'h0,        32'hFFFFFFFF, 5'd1, 1, 5'd0, 0, 5'd0,  1, 5'b00001, 0};
        vecs[9]  = '{"lui",      32'h123452B7, 4'h0, 2'd2, 1, 0, 0, 32'h12345000, 32'hFFFFFFFF, 5'd0, 0, 5'd0, 0, 5'd5,  1, 5'b10000, 0};
        vecs[10] = '{"auipc",    32'hFFFFF397, 4'h0, 2'd1, 1, 0, 0, 32'hFFFFF000, 32'hFFFFFFFF, 5'd0, 0, 5'd0, 0, 5'd7,  1, 5'b10000, 0};
        vecs[11] = '{"zero",     32'h00000000, 4'h0, 2'd0, 0, 0, 0, 32'h0,        32'h0,        5'd0, 1, 5'd0, 1, 5'd0,  1, 5'b00000, 1};
        vecs[12] = '{"sll_bad",  32'h40209133, 4'h0, 2'd0, 0, 0, 0, 32'h0,        32'h0,        5'd1, 1, 5'd2, 1, 5'd2,  1, 5'b00000, 1};
        vecs[13] = '{"slli_bad", 32'h40209113, 4'h0, 2'd0, 0, 0, 0, 32'h0,        32'h0,        5'd1, 1, 5'd0, 0, 5'd2,  1, 5'b00000, 1};
        vecs[14] = '{"xor",      32'h0062C233, 4'h4, 2'd0, 1, 0, 1, 32'h0,        32'h0,        5'd5, 1, 5'd6, 1, 5'd4,  1, 5'b10000, 0};
        vecs[15] = '{"sltiu",    32'h00513093, 4'h9, 2'd0, 1, 1, 1, 32'h5,        32'hFFFFFFFF, 5'd2, 1, 5'd0, 0, 5'd1,  1, 5'b10000, 0};
        vecs[16] = '{"add_x0",   32'h00208033, 4'h0, 2'd0, 1, 0, 1, 32'h0,        32'h0,        5'd1, 1, 5'd2, 1, 5'd0,  1, 5'b00000, 0};
        vecs[17] = '{"jalr_bad", 32'h00009067, 4'h0, 2'd0, 0, 0, 0, 32'h0,        32'h0,        5'd1, 1, 5'd0, 0, 5'd0,  1, 5'b00000, 1};
        vecs[18] = '{"and",      32'h003170B3, 4'hB, 2'd0, 1, 0, 1, 32'h0,        32'h0,        5'd2, 1, 5'd3, 1, 5'd1,  1, 5'b10000, 0};
        vecs[19] = '{"sll",      32'h003110B3, 4'h5, 2'd0, 1, 0, 1, 32'h0,        32'h0,        5'd2, 1, 5'd3, 1, 5'd1,  1, 5'b10000, 0};
        vecs[20] = '{"srl",      32'h003150B3, 4'h6, 2'd0, 1, 0, 1, 32'h0,        32'h0,        5'd2, 1, 5'd3, 1, 5'd1,  1, 5'b10000, 0};
        vecs[21] = '{"slt",      32'h003120B3, 4'h8, 2'd0, 1, 0, 1, 32'h0,        32'h0,        5'd2, 1, 5'd3, 1, 5'd1,  1, 5'b10000, 0};
        vecs[22] = '{"or",       32'h003160B3, 4'hA, 2'd0, 1, 0, 1, 32'h0,        32'h0,        5'd2, 1, 5'd3, 1, 5'd1,  1, 5'b10000, 0};
        vecs[23] = '{"sra",      32'h403150B3, 4'h7, 2'd0, 1, 0, 1, 32'h0,        32'h0,        5'd2, 1, 5'd3, 1, 5'd1,  1, 5'b10000, 0};
        vecs[24] = '{"srli",     32'h00315093, 4'h6, 2'd0, 1, 1, 1, 32'h3,        32'hFFFFFFFF, 5'd2, 1, 5'd0, 0, 5'd1,  1, 5'b10000, 0};

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = '0; pc = '0;
        #12;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.alu_op", alu_op, 0);
        chk("rst.imm", imm, 0);
        chk("rst.flags", {reg_we, mem_re, mem_we, branch, jump, illegal}, 0);
        chk("rst.pc", pc_out, 0);
        #1 rst_n = 1'b1;
        step();

        out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            in_valid = 1'b1;
            instr    = vecs[i].instr;
            pc       = 32'h1000 + 32'(i * 4);
            step();
            chk({vecs[i].name, ".valid"}, out_valid, 1);
            chk({vecs[i].name, ".alu"}, alu_op, vecs[i].alu);
            if (vecs[i].am) chk({vecs[i].name, ".a_sel"}, a_sel, vecs[i].a);
            if (vecs[i].bm) chk({vecs[i].name, ".b_sel"}, b_sel, vecs[i].b);
            if (vecs[i].imask != 0) chk({vecs[i].name, ".imm"}, imm & vecs[i].imask, vecs[i].imm);
            if (vecs[i].rs1m) chk({vecs[i].name, ".rs1"}, rs1, vecs[i].rs1);
            if (vecs[i].rs2m) chk({vecs[i].name, ".rs2"}, rs2, vecs[i].rs2);
            if (vecs[i].rdm) chk({vecs[i].name, ".rd"}, rd, vecs[i].rd);
            chk({vecs[i].name, ".flags"}, {reg_we, mem_re, mem_we, branch, jump}, vecs[i].flags);
            chk({vecs[i].name, ".illegal"}, illegal, vecs[i].ill);
            chk({vecs[i].name, ".funct3"}, funct3, vecs[i].instr[14:12]);
            chk({vecs[i].name, ".pc"}, pc_out, 32'h1000 + 32'(i * 4));
        end
        in_valid = 1'b0;
        step();
        chk("drain.valid", out_valid, 0);

        in_valid = 1'b1; instr = 32'hFFF00093; out_ready = 1'b0;
        step();
        chk("hold.load_valid", out_valid, 1);
        instr = 32'h0062C233;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("hold.in_ready", in_ready, 0);
            chk("hold.valid", out_valid, 1);
            chk("hold.imm", imm, 32'hFFFFFFFF);
            chk("hold.rd", rd, 1);
            chk("hold.alu", alu_op, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("hold.release_ready", in_ready, 1);
        step();
        chk("hold.next_valid", out_valid, 1);
        chk("hold.next_alu", alu_op, 4'h4);
        chk("hold.next_rd", rd, 4);
        in_valid = 1'b0; out_ready = 1'b0;
        step();

        in_valid = 1'b1; instr = 32'h003170B3; out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush.valid", out_valid, 0);
        chk("flush.not_captured", alu_op == 4'hB, 0);
        chk("flush.in_ready", in_ready, 1);

        in_valid = 1'b1; instr = 32'h002081B3;
        step();
        in_valid = 1'b0;
        chk("armst.valid", out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("armst.valid", out_valid, 0);
        chk("armst.reg_we", reg_we, 0);
        chk("armst.rd", rd, 0);
        #2 rst_n = 1'b1;
        step();
        chk("armst.after_release", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
